// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

   localparam int DEF_DVD_W = 8;
   localparam int DEF_DVS_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter must be able to hold DVD_W.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it is non-negative.
module div_sub_stage
   import div_pkg::*;
#(
   parameter int DVS_W = DEF_DVS_W
) (
   input  logic [DVS_W:0]   pr_shift,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W-1:0] pr_next,
   output logic             qbit
);

   localparam int W = DVS_W + 2;

   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     c;
   logic [DVS_W-1:0] diff;
   logic             sign;

   assign a    = {1'b0, pr_shift};
   assign b    = ~{2'b00, divisor};
   assign c[0] = 1'b1;

   // Difference bit DVS_W is not kept: whichever branch is taken, the new
   // partial remainder is below the divisor and fits in DVS_W bits.
   for (genvar i = 0; i < W; i++) begin : g_fa
      if (i < DVS_W) begin : g_sum
         assign diff[i] = a[i] ^ b[i] ^ c[i];
      end
      if (i < W - 1) begin : g_carry
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign sign    = a[W-1] ^ b[W-1] ^ c[W-1];
   assign qbit    = ~sign;
   assign pr_next = qbit ? diff : pr_shift[DVS_W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and a registered divide-by-zero flag.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DVD_W = DEF_DVD_W,
   parameter int DVS_W = DEF_DVS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(DVD_W);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [DVS_W-1:0] pr;
   logic [DVS_W-1:0] pr_next;
   logic [DVD_W-1:0] sr;
   logic [DVD_W-1:0] sr_next;
   logic [DVS_W-1:0] dvs;
   logic             qbit;
   logic             last_iter;

   div_sub_stage #(.DVS_W(DVS_W)) u_sub (
      .pr_shift ({pr, sr[DVD_W-1]}),
      .divisor  (dvs),
      .pr_next  (pr_next),
      .qbit     (qbit)
   );

   assign sr_next   = {sr[DVD_W-2:0], qbit};
   assign last_iter = (cnt == CNT_W'(DVD_W - 1));
   assign busy      = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Results move only on the edge that raises done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         pr          <= '0;
         sr          <= '0;
         dvs         <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvs <= divisor;
                  cnt <= '0;
                  pr  <= '0;
                  sr  <= dividend;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end
               end
            end
            RUN: begin
               pr  <= pr_next;
               sr  <= sr_next;
               cnt <= cnt + 1'b1;
               if (last_iter) begin
                  quotient    <= sr_next;
                  remainder   <= pr_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive-sweep bench for the sequential restoring divider.
module tb_seq_restoring_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   seq_restoring_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Issue one operation and observe 12 cycles after the accept edge.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic z,
                         output int lat, output int nbusy, output int ndone,
                         output logic unstable);
      logic [12:0] held;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      held     = {quotient, remainder, div_by_zero};
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      q = '0; r = '0; z = 1'b0;
      lat = 0; nbusy = 0; ndone = 0; unstable = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               lat = k; q = quotient; r = remainder; z = div_by_zero;
            end
         end else if (ndone == 0 && {quotient, remainder, div_by_zero} !== held) begin
            unstable = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      tests_run++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, done} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [7:0] q; logic [3:0] r; logic z; int lat, nb, nd; logic un;
      run_op(8'd200, 4'd7, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'd28, 4'd4, 1'b0}) begin
         tests_failed++;
         $display("FAIL basic_200_7_result: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0", q, r, z);
      end
      tests_run++;
      if (lat != 9 || nb != 8 || nd != 1 || un !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_200_7_handshake: got lat=%0d busy_cycles=%0d dones=%0d unstable=%b, want 9 8 1 0",
                  lat, nb, nd, un);
      end
   endtask

   task automatic test_max_operands();
      logic [7:0] q; logic [3:0] r; logic z; int lat, nb, nd; logic un;
      run_op(8'd255, 4'd15, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'd17, 4'd0, 1'b0} || nd != 1) begin
         tests_failed++;
         $display("FAIL max_255_15: got q=%0d r=%0d dbz=%b dones=%0d, want q=17 r=0 dbz=0 dones=1", q, r, z, nd);
      end
      run_op(8'd225, 4'd15, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'd15, 4'd0, 1'b0} || nd != 1) begin
         tests_failed++;
         $display("FAIL max_225_15: got q=%0d r=%0d dbz=%b dones=%0d, want q=15 r=0 dbz=0 dones=1", q, r, z, nd);
      end
   endtask

   task automatic test_div_zero();
      logic [7:0] q; logic [3:0] r; logic z; int lat, nb, nd; logic un;
      run_op(8'd13, 4'd0, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'hFF, 4'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL div_zero_result: got q=%h r=%0d dbz=%b, want q=ff r=0 dbz=1", q, r, z);
      end
      tests_run++;
      if (lat != 1 || nb != 0 || nd != 1) begin
         tests_failed++;
         $display("FAIL div_zero_handshake: got lat=%0d busy_cycles=%0d dones=%0d, want 1 0 1", lat, nb, nd);
      end
      run_op(8'd12, 4'd3, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'd4, 4'd0, 1'b0} || nd != 1) begin
         tests_failed++;
         $display("FAIL after_zero_12_3: got q=%0d r=%0d dbz=%b dones=%0d, want q=4 r=0 dbz=0 dones=1", q, r, z, nd);
      end
   endtask

   task automatic test_ignored_start();
      logic [12:0] res;
      int nd;
      res = '0;
      nd  = 0;
      @(negedge clk);
      dividend = 8'd5; divisor = 4'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 3) begin start = 1'b1; dividend = 8'd100; divisor = 4'd10; end
         if (k == 5) start = 1'b0;
         if (done) begin
            nd++;
            if (nd == 1) res = {quotient, remainder, div_by_zero};
         end
      end
      tests_run++;
      if (res !== {8'd0, 4'd5, 1'b0}) begin
         tests_failed++;
         $display("FAIL small_5_9_result: got q=%0d r=%0d dbz=%b, want q=0 r=5 dbz=0", res[12:5], res[4:1], res[0]);
      end
      tests_run++;
      if (nd != 1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_start: got dones=%0d busy_at_end=%b, want 1 0", nd, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] q; logic [3:0] r; logic z; int lat, nb, nd; logic un;
      int stray;
      @(negedge clk);
      dividend = 8'd200; divisor = 4'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_run_busy: got busy=%b, want 1", busy);
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
         tests_failed++;
         $display("FAIL mid_run_reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) stray++;
      end
      tests_run++;
      if (stray != 0) begin
         tests_failed++;
         $display("FAIL mid_run_discard: got %0d cycles with busy/done after reset, want 0", stray);
      end
      run_op(8'd64, 4'd8, q, r, z, lat, nb, nd, un);
      tests_run++;
      if ({q, r, z} !== {8'd8, 4'd0, 1'b0} || nd != 1) begin
         tests_failed++;
         $display("FAIL after_reset_64_8: got q=%0d r=%0d dbz=%b dones=%0d, want q=8 r=0 dbz=0 dones=1", q, r, z, nd);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] q; logic [3:0] r; logic z; int lat, nb, nd; logic un;
      logic [12:0] exp;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (b == 0) exp_q.push_back({8'hFF, 4'd0, 1'b1});
            else        exp_q.push_back({8'(a / b), 4'(a % b), 1'b0});
            run_op(8'(a), 4'(b), q, r, z, lat, nb, nd, un);
            exp = exp_q.pop_front();
            tests_run++;
            if ({q, r, z} !== exp) begin
               tests_failed++;
               $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                        a, b, q, r, z, exp[12:5], exp[4:1], exp[0]);
            end
            tests_run++;
            if (nd != 1 || un !== 1'b0 || nb != ((b == 0) ? 0 : 8) || lat != ((b == 0) ? 1 : 9) ||
                (b != 0 && (int'(q) * b + int'(r) != a || int'(r) >= b))) begin
               tests_failed++;
               $display("FAIL sweep_protocol %0d/%0d: got dones=%0d unstable=%b busy_cycles=%0d lat=%0d q=%0d r=%0d",
                        a, b, nd, un, nb, lat, q, r);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_operands();
      test_div_zero();
      test_ignored_start();
      test_reset_mid_run();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
